// File: rtl/imem_pkg.sv
// Shared types and default geometry for the instruction-memory responder.
package imem_pkg;

  localparam int IMEM_DEPTH        = 1024;
  localparam int IMEM_LINE_WORDS   = 4;
  localparam int IMEM_MISS_LATENCY = 3;

  localparam int WIDX_W = $clog2(IMEM_DEPTH);
  localparam int OFF_W  = $clog2(IMEM_LINE_WORDS);
  localparam int TAG_W  = WIDX_W - OFF_W;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } imem_state_e;

  typedef logic [IMEM_LINE_WORDS-1:0][31:0] line_t;

endpackage

// File: rtl/imem_line_store.sv
// Backing word store organised as whole lines: one word-write port for program
// loading and one combinational full-line read port with write-first bypass.
module imem_line_store
  import imem_pkg::*;
#(
  parameter int DEPTH      = IMEM_DEPTH,
  parameter int LINE_WORDS = IMEM_LINE_WORDS
) (
  input  logic                                    clk_i,
  input  logic                                    ld_we_i,
  input  logic [$clog2(DEPTH)-1:0]                ld_addr_i,
  input  logic [31:0]                             ld_data_i,
  input  logic [$clog2(DEPTH/LINE_WORDS)-1:0]     rd_tag_i,
  output logic [LINE_WORDS-1:0][31:0]             rd_line_o
);

  localparam int IDX_W    = $clog2(DEPTH);
  localparam int OFF_BITS = $clog2(LINE_WORDS);
  localparam int LINES    = DEPTH / LINE_WORDS;

  logic [LINE_WORDS-1:0][31:0] r_mem [LINES];

  logic [IDX_W-OFF_BITS-1:0] w_wr_tag;
  logic [OFF_BITS-1:0]       w_wr_off;

  assign w_wr_tag = ld_addr_i[IDX_W-1:OFF_BITS];
  assign w_wr_off = ld_addr_i[OFF_BITS-1:0];

  // Word write into the addressed line; each word lane maps to its own bank.
  // NOTE: storage arrays carry no reset so they map onto RAM; contents persist across rst_i.
  always_ff @(posedge clk_i) begin
    if (ld_we_i) begin
      r_mem[w_wr_tag][w_wr_off] <= ld_data_i;
    end
  end

  // Full-line read; a same-cycle write to the read line is forwarded into it.
  always_comb begin
    rd_line_o = r_mem[rd_tag_i];
    if (ld_we_i && (w_wr_tag == rd_tag_i)) begin
      rd_line_o[w_wr_off] = ld_data_i;
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: one-line fetch buffer in front of the line store.
// Hits answer combinationally; misses stall the fetcher for MISS_LATENCY cycles.
module imem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH        = IMEM_DEPTH,
  parameter int LINE_WORDS   = IMEM_LINE_WORDS,
  parameter int MISS_LATENCY = IMEM_MISS_LATENCY
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [31:0]              im_addr_i,
  output logic                     im_busy_o,
  output logic [31:0]              im_dout_o,
  input  logic                     ld_we_i,
  input  logic [$clog2(DEPTH)-1:0] ld_addr_i,
  input  logic [31:0]              ld_data_i,
  output logic [31:0]              miss_cnt_o
);

  localparam int IDX_W    = $clog2(DEPTH);
  localparam int OFF_BITS = $clog2(LINE_WORDS);
  localparam int TAG_BITS = IDX_W - OFF_BITS;
  localparam int CNT_W    = $clog2(MISS_LATENCY);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(MISS_LATENCY - 2);

  imem_state_e r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_fill_cnt, w_fill_cnt_nxt;
  logic [TAG_BITS-1:0] r_fill_tag, w_fill_tag_nxt;
  logic                r_line_valid;
  logic [TAG_BITS-1:0] r_line_tag;
  logic [LINE_WORDS-1:0][31:0] r_line_data;
  logic [31:0]         r_miss_cnt;

  logic [IDX_W-1:0]    w_widx;
  logic [TAG_BITS-1:0] w_tag;
  logic [OFF_BITS-1:0] w_off;
  logic [TAG_BITS-1:0] w_ld_tag;
  logic                w_hit;
  logic                w_miss;
  logic                w_install;
  logic [LINE_WORDS-1:0][31:0] w_store_line;
  logic                w_unused_addr;

  // Address split; upper bits alias modulo DEPTH and the byte offset is ignored.
  assign w_widx        = im_addr_i[IDX_W+1:2];
  assign w_tag         = w_widx[IDX_W-1:OFF_BITS];
  assign w_off         = w_widx[OFF_BITS-1:0];
  assign w_ld_tag      = ld_addr_i[IDX_W-1:OFF_BITS];
  assign w_hit         = r_line_valid && (r_line_tag == w_tag);
  assign w_unused_addr = ^{im_addr_i[31:IDX_W+2], im_addr_i[1:0]};
  assign miss_cnt_o    = r_miss_cnt;

  imem_line_store #(
    .DEPTH      (DEPTH),
    .LINE_WORDS (LINE_WORDS)
  ) u_store (
    .clk_i     (clk_i),
    .ld_we_i   (ld_we_i),
    .ld_addr_i (ld_addr_i),
    .ld_data_i (ld_data_i),
    .rd_tag_i  (r_fill_tag),
    .rd_line_o (w_store_line)
  );

  // Next-state, fill countdown and fetch response.
  // NOTE: every output of this block gets a default first so no path leaves a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_fill_cnt_nxt = r_fill_cnt;
    w_fill_tag_nxt = r_fill_tag;
    w_miss         = 1'b0;
    w_install      = 1'b0;
    im_busy_o      = 1'b1;
    im_dout_o      = '0;
    if (!rst_i) begin
      unique case (r_state)
        IDLE: begin
          if (w_hit) begin
            im_busy_o = 1'b0;
            im_dout_o = r_line_data[w_off];
          end else begin
            w_miss         = 1'b1;
            w_fill_tag_nxt = w_tag;
            w_fill_cnt_nxt = CNT_RELOAD;
            w_state_nxt    = FILL;
          end
        end
        FILL: begin
          // A load into the line being filled restarts the countdown.
          if (ld_we_i && (w_ld_tag == r_fill_tag)) begin
            w_fill_cnt_nxt = CNT_RELOAD;
          end else if (r_fill_cnt == '0) begin
            w_install   = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_fill_cnt_nxt = r_fill_cnt - CNT_W'(1);
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // FSM state, fill bookkeeping and saturating miss counter.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_fill_cnt <= '0;
      r_fill_tag <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fill_cnt <= w_fill_cnt_nxt;
      r_fill_tag <= w_fill_tag_nxt;
      if (w_miss && (r_miss_cnt != 32'hFFFF_FFFF)) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  // Line buffer: loads to the buffered line invalidate it; an install wins on the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_line_valid <= 1'b0;
    end else begin
      if (ld_we_i && (w_ld_tag == r_line_tag)) begin
        r_line_valid <= 1'b0;
      end
      if (w_install) begin
        r_line_valid <= 1'b1;
        r_line_tag   <= r_fill_tag;
        r_line_data  <= w_store_line;
      end
    end
  end

endmodule
